// File: rtl/bus_master_if_pkg.sv
// Shared constants for the per-master bus interface: strobe polarities,
// read/write encodings, FSM state codes and the timeout counter width.
package bus_master_if_pkg;

   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;

   localparam logic READ  = 1'b1;
   localparam logic WRITE = 1'b0;

   typedef logic [2:0] bm_state_t;

   localparam bm_state_t BM_IDLE = 3'd0;
   localparam bm_state_t BM_REQ  = 3'd1;
   localparam bm_state_t BM_STRB = 3'd2;
   localparam bm_state_t BM_WAIT = 3'd3;
   localparam bm_state_t BM_DONE = 3'd4;

   localparam int unsigned TMO_CNT_W = 16;

endpackage

// File: rtl/bus_master_if_timeout_cnt.sv
// Clearable/enabled cycle counter; tc flags the cycle whose increment
// would make the count reach TIMEOUT.
module bus_master_if_timeout_cnt
   import bus_master_if_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
)(
   input  logic clk,
   input  logic reset_,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [TMO_CNT_W-1:0] LAST = TMO_CNT_W'(TIMEOUT - 1);

   logic [TMO_CNT_W-1:0] cnt_r;

   // Count enabled cycles since the last clear
   always_ff @(posedge clk) begin
      if (!reset_) begin
         cnt_r <= {TMO_CNT_W{1'b0}};
      end else if (clr) begin
         cnt_r <= {TMO_CNT_W{1'b0}};
      end else if (en) begin
         cnt_r <= cnt_r + TMO_CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign tc = en && (cnt_r == LAST);

endmodule

// File: rtl/bus_master_if.sv
// Single-word bus master: requests the bus, runs one strobe/wait cycle and
// returns data/status to its client. All outputs are registered.
module bus_master_if
   import bus_master_if_pkg::*;
#(
   parameter int unsigned ADDR_W  = 30,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
)(
   input  logic              clk,
   input  logic              reset_,
   input  logic              req,
   input  logic              rw,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              ack,
   output logic              err,
   output logic [DATA_W-1:0] rd_data,
   output logic              breq_,
   input  logic              bgrt_,
   output logic              bus_as_,
   output logic              bus_rw,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_rdy_
);

   bm_state_t         state_r;
   bm_state_t         state_nxt_s;
   logic              cmd_rw_r;
   logic [ADDR_W-1:0] cmd_addr_r;
   logic [DATA_W-1:0] cmd_wdata_r;
   logic              tmo_s;
   logic              rdy_s;
   logic              req_phase_s;
   logic              bus_phase_s;
   logic              finish_s;

   assign rdy_s       = (bus_rdy_ == ENABLE_);
   assign req_phase_s = (state_nxt_s == BM_REQ) || (state_nxt_s == BM_STRB) || (state_nxt_s == BM_WAIT);
   assign bus_phase_s = (state_nxt_s == BM_STRB) || (state_nxt_s == BM_WAIT);
   assign finish_s    = (state_r == BM_WAIT) && (state_nxt_s == BM_DONE);

   bus_master_if_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_tmo (
      .clk    (clk),
      .reset_ (reset_),
      .clr    (state_r == BM_STRB),
      .en     (state_r == BM_WAIT),
      .tc     (tmo_s)
   );

   // Next-state decode; a ready on the timeout edge still completes cleanly
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         BM_IDLE: if (req) state_nxt_s = BM_REQ; else state_nxt_s = BM_IDLE;
         BM_REQ:  if (bgrt_ == ENABLE_) state_nxt_s = BM_STRB; else state_nxt_s = BM_REQ;
         BM_STRB: state_nxt_s = BM_WAIT;
         BM_WAIT: if (rdy_s || tmo_s) state_nxt_s = BM_DONE; else state_nxt_s = BM_WAIT;
         BM_DONE: state_nxt_s = BM_IDLE;
         default: state_nxt_s = BM_IDLE;
      endcase
   end

   // Command capture at acceptance; later req pulses are ignored until IDLE
   always_ff @(posedge clk) begin
      if (!reset_) begin
         cmd_rw_r    <= 1'b0;
         cmd_addr_r  <= {ADDR_W{1'b0}};
         cmd_wdata_r <= {DATA_W{1'b0}};
      end else if ((state_r == BM_IDLE) && req) begin
         cmd_rw_r    <= rw;
         cmd_addr_r  <= addr;
         cmd_wdata_r <= wr_data;
      end else begin
         cmd_rw_r    <= cmd_rw_r;
         cmd_addr_r  <= cmd_addr_r;
         cmd_wdata_r <= cmd_wdata_r;
      end
   end

   // State, client and bus outputs registered from the next state, so bus
   // lines are zero outside STRB/WAIT and can be OR-combined downstream
   always_ff @(posedge clk) begin
      if (!reset_) begin
         state_r   <= BM_IDLE;
         busy      <= 1'b0;
         ack       <= 1'b0;
         err       <= 1'b0;
         rd_data   <= {DATA_W{1'b0}};
         breq_     <= DISABLE_;
         bus_as_   <= DISABLE_;
         bus_rw    <= 1'b0;
         bus_addr  <= {ADDR_W{1'b0}};
         bus_wdata <= {DATA_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         busy    <= (state_nxt_s != BM_IDLE);
         ack     <= (state_nxt_s == BM_DONE);
         breq_   <= req_phase_s ? ENABLE_ : DISABLE_;
         bus_as_ <= (state_nxt_s == BM_STRB) ? ENABLE_ : DISABLE_;
         if (bus_phase_s) begin
            bus_rw    <= cmd_rw_r;
            bus_addr  <= cmd_addr_r;
            bus_wdata <= (cmd_rw_r == WRITE) ? cmd_wdata_r : {DATA_W{1'b0}};
         end else begin
            bus_rw    <= 1'b0;
            bus_addr  <= {ADDR_W{1'b0}};
            bus_wdata <= {DATA_W{1'b0}};
         end
         if (finish_s) begin
            err <= rdy_s ? 1'b0 : 1'b1;
            if (rdy_s && (cmd_rw_r == READ)) begin
               rd_data <= bus_rdata;
            end else begin
               rd_data <= rd_data;
            end
         end else begin
            err     <= err;
            rd_data <= rd_data;
         end
      end
   end

endmodule

// File: tb/tb_bus_master_if.sv
// Randomized bench for bus_master_if: a cycle-count reference model for a
// single master plus a two-master run behind a small arbiter model.
module tb_bus_master_if;

   localparam int AW = 30;
   localparam int DW = 32;
   localparam int TO = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_;
   logic          req0, rw0, req1, rw1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wd0, wd1;
   logic          m0_busy, m0_ack, m0_err, m0_breq_, m0_as_, m0_rw;
   logic          m1_busy, m1_ack, m1_err, m1_breq_, m1_as_, m1_rw;
   logic [DW-1:0] m0_rd, m1_rd, m0_wd, m1_wd;
   logic [AW-1:0] m0_addr, m1_addr;
   logic          bgrt0_, bgrt1_, tb_g0_, arb_mode, owner_r;
   logic          bus_rdy_;
   logic [DW-1:0] bus_rdata;
   logic [DW-1:0] model_rd;

   int checks = 0;
   int errors = 0;

   assign bgrt0_ = arb_mode ? owner_r : tb_g0_;
   assign bgrt1_ = arb_mode ? ~owner_r : 1'b1;

   // Two-master arbiter model: grant parked on master 0, held while the owner requests
   always @(posedge clk) begin
      if (!arb_mode)                                owner_r <= 1'b0;
      else if (!owner_r && m0_breq_ && !m1_breq_)   owner_r <= 1'b1;
      else if (owner_r && m1_breq_ && !m0_breq_)    owner_r <= 1'b0;
   end

   bus_master_if #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) u_m0 (
      .clk(clk), .reset_(reset_), .req(req0), .rw(rw0), .addr(addr0), .wr_data(wd0),
      .busy(m0_busy), .ack(m0_ack), .err(m0_err), .rd_data(m0_rd),
      .breq_(m0_breq_), .bgrt_(bgrt0_), .bus_as_(m0_as_), .bus_rw(m0_rw),
      .bus_addr(m0_addr), .bus_wdata(m0_wd), .bus_rdata(bus_rdata), .bus_rdy_(bus_rdy_));

   bus_master_if #(.ADDR_W(AW), .DATA_W(DW)) u_m1 (
      .clk(clk), .reset_(reset_), .req(req1), .rw(rw1), .addr(addr1), .wr_data(wd1),
      .busy(m1_busy), .ack(m1_ack), .err(m1_err), .rd_data(m1_rd),
      .breq_(m1_breq_), .bgrt_(bgrt1_), .bus_as_(m1_as_), .bus_rw(m1_rw),
      .bus_addr(m1_addr), .bus_wdata(m1_wd), .bus_rdata(bus_rdata), .bus_rdy_(bus_rdy_));

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One master-0 command. gd = cycles breq_ waits for grant, rd = wait cycles
   // before the slave answers. Expected timing follows from the state dwell times:
   // REQ gd+1, STRB 1, WAIT min(rd+1, TO), DONE 1.
   task automatic run_txn(input logic r, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input int gd, input int rd, input logic [DW-1:0] rdat, input bit busy_req);
      bit ok;
      int strb, ackc;
      logic [3:0] ctl;
      bit act;
      ok   = (rd + 1 <= TO);
      strb = 2 + gd;
      ackc = strb + (ok ? rd + 1 : TO) + 1;
      req0 = 1'b1; rw0 = r; addr0 = a; wd0 = wd;
      tb_g0_ = (gd == 0) ? 1'b0 : 1'b1;
      bus_rdy_ = 1'b1;
      for (int c = 1; c <= ackc + 1; c++) begin
         @(negedge clk);
         ctl = {c <= ackc, c == ackc, !(c < ackc), c != strb};
         act = (c >= strb) && (c < ackc);
         check_eq("ctl busy/ack/breq_/as_", 64'({m0_busy, m0_ack, m0_breq_, m0_as_}), 64'(ctl));
         check_eq("bus_rw", 64'(m0_rw), 64'(act ? r : 1'b0));
         check_eq("bus_addr", 64'(m0_addr), 64'(act ? a : {AW{1'b0}}));
         check_eq("bus_wdata", 64'(m0_wd), 64'((act && !r) ? wd : {DW{1'b0}}));
         if (c == ackc) begin
            if (ok && r) model_rd = rdat;
            check_eq("err", 64'(m0_err), 64'(!ok));
         end
         check_eq("rd_data", 64'(m0_rd), 64'(model_rd));
         req0  = (busy_req && (c == strb + 1)) ? 1'b1 : 1'b0;
         addr0 = ~a;
         if (gd > 0 && c == 1 + gd) tb_g0_ = 1'b0;
         if (c == strb + 1 + rd) begin
            bus_rdy_ = 1'b0; bus_rdata = rdat;
         end else begin
            bus_rdy_ = 1'b1; bus_rdata = $urandom;
         end
      end
      bus_rdy_ = 1'b1;
   endtask

   task automatic reset_mid_wait();
      req0 = 1'b1; rw0 = 1'b1; addr0 = 30'h155; wd0 = 32'h0; tb_g0_ = 1'b0; bus_rdy_ = 1'b1;
      @(negedge clk); req0 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_eq("in WAIT before reset", 64'({m0_busy, m0_breq_, m0_as_}), 64'(3'b101));
      reset_ = 1'b0;
      @(negedge clk);
      reset_ = 1'b1;
      model_rd = {DW{1'b0}};
      check_eq("reset ctl", 64'({m0_busy, m0_ack, m0_err, m0_breq_, m0_as_}), 64'(5'b00011));
      check_eq("reset bus", 64'({m0_rw, m0_addr, m0_wd}), 64'(0));
      check_eq("reset rd_data", 64'(m0_rd), 64'(model_rd));
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check_eq("idle after reset", 64'({m0_busy, m0_ack, m0_breq_}), 64'(3'b001));
      end
   endtask

   // Both masters request together; master 0 owns the parked grant
   task automatic arb_run();
      int ack0c, ack1c;
      bit prev_as, act0, act1;
      localparam logic [DW-1:0] ARB_RD = 32'hA5A5_0F0F;
      arb_mode = 1'b1;
      @(negedge clk);
      ack0c = -1; ack1c = -1; prev_as = 1'b0;
      req0 = 1'b1; rw0 = 1'b1; addr0 = 30'h55; wd0 = 32'h0;
      req1 = 1'b1; rw1 = 1'b0; addr1 = 30'h66; wd1 = 32'hCAFE_0001;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         req0 = 1'b0; req1 = 1'b0;
         if (m0_ack && ack0c < 0) ack0c = c;
         if (m1_ack && ack1c < 0) ack1c = c;
         act0 = !m0_as_ || (m0_addr != '0) || (m0_wd != '0) || m0_rw;
         act1 = !m1_as_ || (m1_addr != '0) || (m1_wd != '0) || m1_rw;
         check_eq("bus overlap", 64'(act0 && act1), 64'(0));
         if (!m1_as_) check_eq("m1 strobe after m0 release", 64'(m0_breq_), 64'(1'b1));
         bus_rdy_  = prev_as ? 1'b0 : 1'b1;
         bus_rdata = ARB_RD;
         prev_as   = !m0_as_ || !m1_as_;
      end
      model_rd = ARB_RD;
      check_eq("m0 ack cycle", 64'(ack0c), 64'(4));
      check_eq("m1 ack cycle", 64'(ack1c), 64'(8));
      check_eq("m0 arb rd_data", 64'(m0_rd), 64'(model_rd));
      check_eq("arb errs", 64'({m0_err, m1_err}), 64'(2'b00));
      check_eq("m1 wr addr seen", 64'(u_m1.bus_addr), 64'(0));
      arb_mode = 1'b0;
      bus_rdy_ = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      reset_ = 1'b0; arb_mode = 1'b0; tb_g0_ = 1'b1;
      req0 = 1'b0; rw0 = 1'b0; addr0 = '0; wd0 = '0;
      req1 = 1'b0; rw1 = 1'b0; addr1 = '0; wd1 = '0;
      bus_rdy_ = 1'b1; bus_rdata = '0; model_rd = '0;
      repeat (3) @(negedge clk);
      check_eq("reset m0 ctl", 64'({m0_busy, m0_ack, m0_err, m0_breq_, m0_as_}), 64'(5'b00011));
      check_eq("reset m0 bus", 64'({m0_rw, m0_addr, m0_wd}), 64'(0));
      check_eq("reset m0 rd_data", 64'(m0_rd), 64'(0));
      check_eq("reset m1 ctl", 64'({m1_busy, m1_ack, m1_err, m1_breq_, m1_as_}), 64'(5'b00011));
      reset_ = 1'b1;
      @(negedge clk);

      run_txn(1'b1, 30'h100, 32'h0,         0, 0, 32'hDEADBEEF, 1'b0);
      run_txn(1'b0, 30'h2A,  32'h12345678,  5, 0, 32'h11111111, 1'b0);
      run_txn(1'b1, 30'h3C0, 32'h0,         0, 2, 32'h0BADF00D, 1'b0);
      run_txn(1'b1, 30'h7,   32'h0,         0, 9, 32'h77777777, 1'b0);
      run_txn(1'b1, 30'h8,   32'h0,         1, 3, 32'h88880001, 1'b0);
      run_txn(1'b0, 30'h9,   32'h99990002,  2, 1, 32'h0,        1'b1);
      reset_mid_wait();

      for (int n = 0; n < 24; n++) begin
         run_txn(1'($urandom_range(0, 1)), AW'($urandom), $urandom,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), $urandom,
                 1'($urandom_range(0, 1)));
      end

      arb_run();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
